// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: 2-way I-cache miss/refill sequencer (burst fetch, victim-way write, tag refresh).
// Optional build macro ICACHE_REFILL_CRITWORD_EN: critical-word-first wrap burst plus fwd_valid_o/fwd_data_o.
module icache_refill_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LINE_BEATS = 4,
  parameter int INDEX_W = 6,
  localparam int OFF_W = $clog2(LINE_BEATS * DATA_W / 8),
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic lru_i,
  input  logic flush_i,
  output logic stallreq_o,
  output logic refresh_o,
  output logic ar_valid_o,
  output logic [ADDR_W-1:0] ar_addr_o,
  output logic [7:0] ar_len_o,
  input  logic ar_ready_i,
  input  logic r_valid_i,
  input  logic [DATA_W-1:0] r_data_i,
  input  logic r_last_i,
  output logic r_ready_o,
  output logic [1:0] dwe_o,
  output logic [INDEX_W-1:0] d_index_o,
  output logic [BEAT_W-1:0] d_beat_o,
  output logic [DATA_W-1:0] d_wdata_o
`ifdef ICACHE_REFILL_CRITWORD_EN
  ,
  output logic fwd_valid_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);
`ifdef ICACHE_REFILL_CRITWORD_EN
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << BYTE_W;
`else
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
`endif
  localparam logic [BEAT_W-1:0] BEAT_MASK = BEAT_W'(LINE_BEATS - 1);
  typedef enum logic [2:0] {IDLE, REQ, RECV, FILL, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic way_q, way_d, abort_q, abort_d, abort_now;
`ifdef ICACHE_REFILL_CRITWORD_EN
  logic first_q, first_d;
`endif
  assign abort_now = abort_q | flush_i;
  assign stallreq_o = miss_i | (state_q != IDLE);
  // next-state and bus/data-array outputs; a flush this cycle already suppresses writes and refresh
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    way_d = way_q;
    beat_d = beat_q;
    abort_d = abort_q;
    ar_valid_o = 1'b0;
    ar_addr_o = '0;
    ar_len_o = '0;
    r_ready_o = 1'b0;
    refresh_o = 1'b0;
    dwe_o = '0;
    d_index_o = '0;
    d_beat_o = '0;
    d_wdata_o = '0;
`ifdef ICACHE_REFILL_CRITWORD_EN
    first_d = first_q;
    fwd_valid_o = 1'b0;
    fwd_data_o = '0;
`endif
    case (state_q)
      IDLE: if (miss_i && !flush_i) begin
        state_d = REQ;
        addr_d = miss_addr_i & ADDR_MASK;
        way_d = lru_i;
        abort_d = 1'b0;
`ifdef ICACHE_REFILL_CRITWORD_EN
        beat_d = miss_addr_i[BYTE_W +: BEAT_W] & BEAT_MASK;
        first_d = 1'b1;
`else
        beat_d = '0;
`endif
      end
      REQ: begin
        ar_valid_o = 1'b1;
        ar_addr_o = addr_q;
        ar_len_o = 8'(LINE_BEATS - 1);
        abort_d = abort_now;
        state_d = ar_ready_i ? RECV : REQ;
      end
      RECV: begin
        r_ready_o = 1'b1;
        abort_d = abort_now;
        if (r_valid_i) begin
          dwe_o = abort_now ? 2'b00 : (way_q ? 2'b10 : 2'b01);
          d_index_o = addr_q[OFF_W +: INDEX_W];
          d_beat_o = beat_q;
          d_wdata_o = r_data_i;
          beat_d = (beat_q + 1'b1) & BEAT_MASK;
`ifdef ICACHE_REFILL_CRITWORD_EN
          fwd_valid_o = first_q & ~abort_now;
          fwd_data_o = fwd_valid_o ? r_data_i : '0;
          first_d = 1'b0;
`endif
          state_d = r_last_i ? (abort_now ? DONE : FILL) : RECV;
        end
      end
      FILL: begin
        refresh_o = ~abort_now;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and latched miss context; reset drops any burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      way_q <= 1'b0;
      beat_q <= '0;
      abort_q <= 1'b0;
`ifdef ICACHE_REFILL_CRITWORD_EN
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      way_q <= way_d;
      beat_q <= beat_d;
      abort_q <= abort_d;
`ifdef ICACHE_REFILL_CRITWORD_EN
      first_q <= first_d;
`endif
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: table-driven cycle vectors plus hand-written corner sequences for icache_refill_ctrl.
module tb_icache_refill_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, miss, lru, flush, ar_ready, r_valid, r_last;
  logic [63:0] miss_addr, r_data;
  logic stallreq, refresh, ar_valid, r_ready;
  logic [63:0] ar_addr, d_wdata;
  logic [7:0] ar_len;
  logic [1:0] dwe, d_beat;
  logic [5:0] d_index;
`ifdef ICACHE_REFILL_CRITWORD_EN
  logic fwd_valid;
  logic [63:0] fwd_data;
`endif

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_i(miss), .miss_addr_i(miss_addr), .lru_i(lru), .flush_i(flush),
    .stallreq_o(stallreq), .refresh_o(refresh), .ar_valid_o(ar_valid), .ar_addr_o(ar_addr),
    .ar_len_o(ar_len), .ar_ready_i(ar_ready), .r_valid_i(r_valid), .r_data_i(r_data),
    .r_last_i(r_last), .r_ready_o(r_ready), .dwe_o(dwe), .d_index_o(d_index), .d_beat_o(d_beat),
    .d_wdata_o(d_wdata)
`ifdef ICACHE_REFILL_CRITWORD_EN
    , .fwd_valid_o(fwd_valid), .fwd_data_o(fwd_data)
`endif
  );

  typedef struct packed {
    logic rst, miss;
    logic [63:0] addr;
    logic lru, flush, ar_ready, r_valid;
    logic [63:0] r_data;
    logic r_last;
  } in_t;
  typedef struct packed {
    logic stall, refresh, ar_valid;
    logic [63:0] ar_addr;
    logic [7:0] ar_len;
    logic r_ready;
    logic [1:0] dwe;
    logic [5:0] d_index;
    logic [1:0] d_beat;
    logic [63:0] d_wdata;
  } out_t;
  typedef struct packed {
    in_t vi;
    out_t vo;
  } vec_t;

  localparam logic [63:0] A = 64'h8000_0048, LA = 64'h8000_0040;
  localparam logic [63:0] B = 64'h1234_5678, LB = 64'h1234_5660;
  localparam logic [63:0] C = 64'h100, G = 64'h7E0;

  vec_t vq[$];
  int total = 0, bad = 0;
  int writes, pulses, cyc;
  logic [1:0] last_beat;
  out_t act;

  task automatic apply(input in_t v);
    @(negedge clk);
    {rst, miss, miss_addr, lru, flush, ar_ready, r_valid, r_data, r_last} = v;
    #1;
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic in_t drv(input logic r, m, input logic [63:0] a, input logic l, f, ar, rv,
                              input logic [63:0] rd, input logic rl);
    drv = '{r, m, a, l, f, ar, rv, rd, rl};
  endfunction
  function automatic in_t in_nop();
    return drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic in_t in_go();
    return drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
  endfunction
  function automatic in_t in_miss(input logic [63:0] a, input logic l);
    return drv(0, 1, a, l, 0, 1, 0, 0, 0);
  endfunction
  function automatic in_t in_beat(input logic [63:0] rd, input logic rl, input logic f);
    return drv(0, 0, 0, 0, f, 0, 1, rd, rl);
  endfunction

  function automatic void add(input in_t vi, input logic st, rf, av, input logic [63:0] aa,
                              input logic rr, input logic [1:0] we, input logic [5:0] ix,
                              input logic [1:0] bt, input logic [63:0] wd);
    vec_t v;
    v.vi = vi;
    v.vo = '{st, rf, av, aa, av ? 8'd3 : 8'd0, rr, we, ix, bt, wd};
    vq.push_back(v);
  endfunction
  function automatic void row_idle(input in_t vi);
    add(vi, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic void row_stall(input in_t vi);
    add(vi, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic void row_req(input in_t vi, input logic [63:0] aa);
    add(vi, 1, 0, 1, aa, 0, 0, 0, 0, 0);
  endfunction
  function automatic void row_beat(input in_t vi, input logic [1:0] we, input logic [5:0] ix,
                                   input logic [1:0] bt, input logic [63:0] wd);
    add(vi, 1, 0, 0, 0, 1, we, ix, bt, wd);
  endfunction
  function automatic void row_fill(input in_t vi, input logic rf);
    add(vi, 1, rf, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic void burst(input logic [1:0] we, input logic [5:0] ix, input logic [63:0] base);
    for (int k = 0; k < 4; k++)
      row_beat(in_beat(base + 64'(k), k == 3, 0), we, ix, 2'(k), base + 64'(k));
  endfunction

  initial begin
    {rst, miss, miss_addr, lru, flush, ar_ready, r_valid, r_data, r_last} = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
`ifndef ICACHE_REFILL_CRITWORD_EN
    row_idle(drv(1, 0, 0, 0, 0, 0, 0, 0, 0));
    row_idle(in_nop());
    // basic refill into way1, 7 busy cycles
    row_stall(in_miss(A, 1));
    row_req(in_go(), LA);
    burst(2'b10, 6'd2, 64'hD000_0000_0000_0000);
    row_fill(in_nop(), 1);
    row_stall(in_nop());
    row_idle(in_nop());
    // ar_ready held low 5 cycles, then gappy r_valid 1,0,0,1,1,0,1
    row_stall(in_miss(B, 0));
    repeat (5) row_req(in_nop(), LB);
    row_req(in_go(), LB);
    row_beat(in_beat(64'hE0, 0, 0), 2'b01, 6'h33, 0, 64'hE0);
    row_beat(in_nop(), 0, 0, 0, 0);
    row_beat(in_nop(), 0, 0, 0, 0);
    row_beat(in_beat(64'hE1, 0, 0), 2'b01, 6'h33, 1, 64'hE1);
    row_beat(in_beat(64'hE2, 0, 0), 2'b01, 6'h33, 2, 64'hE2);
    row_beat(in_nop(), 0, 0, 0, 0);
    row_beat(in_beat(64'hE3, 1, 0), 2'b01, 6'h33, 3, 64'hE3);
    row_fill(in_nop(), 1);
    row_stall(in_nop());
    row_idle(in_nop());
    // flush during beat 2: remaining beats drain unwritten, no refresh
    row_stall(in_miss(C, 0));
    row_req(in_go(), C);
    row_beat(in_beat(64'hF0, 0, 0), 2'b01, 6'd8, 0, 64'hF0);
    row_beat(in_beat(64'hF1, 0, 0), 2'b01, 6'd8, 1, 64'hF1);
    row_beat(in_beat(64'hF2, 0, 1), 2'b00, 6'd8, 2, 64'hF2);
    row_beat(in_beat(64'hF3, 1, 0), 2'b00, 6'd8, 3, 64'hF3);
    row_stall(in_nop());
    row_idle(in_nop());
    // miss together with flush in IDLE is ignored
    row_stall(drv(0, 1, C, 0, 1, 1, 0, 0, 0));
    row_idle(in_nop());
    // flush in FILL kills the refresh pulse, top index
    row_stall(in_miss(G, 1));
    row_req(in_go(), G);
    burst(2'b10, 6'h3F, 64'hAA00);
    row_fill(drv(0, 0, 0, 0, 1, 0, 0, 0, 0), 0);
    row_stall(in_nop());
    row_idle(in_nop());
    // flush on the r_last beat: abort wins
    row_stall(in_miss(G, 0));
    row_req(in_go(), G);
    for (int k = 0; k < 3; k++) row_beat(in_beat(64'hBB00 + 64'(k), 0, 0), 2'b01, 6'h3F, 2'(k), 64'hBB00 + 64'(k));
    row_beat(in_beat(64'hBB03, 1, 1), 2'b00, 6'h3F, 3, 64'hBB03);
    row_stall(in_nop());
    row_idle(in_nop());
    // reset mid-burst, then a clean refill from beat 0
    row_stall(in_miss(A, 0));
    row_req(in_go(), LA);
    row_beat(in_beat(64'hCC0, 0, 0), 2'b01, 6'd2, 0, 64'hCC0);
    row_beat(drv(1, 0, 0, 0, 0, 0, 1, 64'hCC1, 0), 2'b01, 6'd2, 1, 64'hCC1);
    row_idle(in_nop());
    row_stall(in_miss(B, 1));
    row_req(in_go(), LB);
    burst(2'b10, 6'h33, 64'hDD00);
    row_fill(in_nop(), 1);
    row_stall(in_nop());
    row_idle(in_nop());
    for (int n = 0; n < vq.size(); n++) begin
      apply(vq[n].vi);
      act = '{stallreq, refresh, ar_valid, ar_addr, ar_len, r_ready, dwe, d_index, d_beat, d_wdata};
      total++;
      if (act !== vq[n].vo) begin
        bad++;
        $display("FAIL row%0d: got %h want %h", n, act, vq[n].vo);
      end
    end
`else
    apply(in_nop());
    cmp("cw_reset_stall", stallreq, 0);
    apply(in_miss(64'h8000_0058, 0));
    cmp("cw_stall", stallreq, 1);
    apply(in_go());
    cmp("cw_ar_valid", ar_valid, 1);
    cmp("cw_ar_addr", ar_addr, 64'h8000_0058);
    for (int k = 0; k < 4; k++) begin
      apply(in_beat(64'hCC00 + 64'(k), k == 3, 0));
      cmp("cw_beat", d_beat, 64'((3 + k) % 4));
      cmp("cw_dwe", dwe, 1);
      cmp("cw_index", d_index, 2);
      cmp("cw_fwd_valid", fwd_valid, k == 0);
      cmp("cw_fwd_data", fwd_data, k == 0 ? 64'hCC00 : 64'h0);
    end
    apply(in_nop());
    cmp("cw_refresh", refresh, 1);
    apply(in_nop());
    cmp("cw_done_stall", stallreq, 1);
    apply(in_nop());
    cmp("cw_idle_stall", stallreq, 0);
`endif
    // early r_last on beat 1: line installed as-is, must return to IDLE within budget
    writes = 0;
    pulses = 0;
    cyc = 0;
    last_beat = '0;
    apply(in_miss(C, 1));
    do begin
      apply(drv(0, 0, 0, 0, 0, 1, 1, 64'hC0 + 64'(writes), writes == 1));
      if (dwe != 2'b00) begin
        writes++;
        last_beat = d_beat;
      end
      if (refresh) pulses++;
      cyc++;
    end while (stallreq && cyc < 20);
    cmp("perr_no_hang", stallreq, 0);
    cmp("perr_writes", 64'(writes), 2);
    cmp("perr_refresh", 64'(pulses), 1);
    cmp("perr_last_beat", last_beat, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
